// File: rtl/aes_stream_transactor.sv
// Credit-flow front end for a fixed-latency AES encoder/decoder pair.
// Tracks vectors in flight, checks both core results in order and queues tagged results.
module aes_stream_transactor #(
    parameter int KEY_BITS = 128,
    parameter int LATENCY  = 10,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_plain,
    input  logic [127:0]        in_cipher,
    input  logic [KEY_BITS-1:0] in_key,
    input  logic                in_eom,
    output logic [127:0]        dut_plain,
    output logic [127:0]        dut_cipher,
    output logic [KEY_BITS-1:0] dut_key,
    input  logic [127:0]        dut_encrypt,
    input  logic [127:0]        dut_decrypt,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [127:0]        res_encrypt,
    output logic [127:0]        res_decrypt,
    output logic                res_enc_ok,
    output logic                res_dec_ok,
    output logic [CNT_W-1:0]    res_tag,
    output logic [CNT_W-1:0]    pass_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic                done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(2 * DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [127:0]     cipher;
        logic [127:0]     plain;
        logic [CNT_W-1:0] tag;
    } exp_t;

    typedef struct packed {
        logic [127:0]     encrypt;
        logic [127:0]     decrypt;
        logic             enc_ok;
        logic             dec_ok;
        logic [CNT_W-1:0] tag;
    } res_t;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic [LATENCY:0]     valid_q;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CNT_W-1:0]     tag_q;
    logic [127:0]         dut_plain_q, dut_cipher_q;
    logic [KEY_BITS-1:0]  dut_key_q;

    exp_t                 exp_mem [DEPTH];
    exp_t                 exp_head_q;
    logic [AW-1:0]        exp_wr_q, exp_rd_q;

    res_t                 res_mem [DEPTH];
    res_t                 res_head_q;
    res_t                 cap_entry;
    logic [AW-1:0]        res_wr_q, res_rd_q, res_rd_d;
    logic [CW-1:0]        res_cnt_q, res_cnt_d;
    logic                 res_valid_q;

    logic [CNT_W-1:0]     pass_count_q, fail_count_q;

    logic                 accept, pop, prefetch, capture, head_from_cap;

    always_comb begin
        accept        = in_valid && in_ready_q;
        pop           = res_valid_q && res_ready;
        // Pipe stage LATENCY lines up with the core output; one stage earlier
        // fetches the matching expected entry from RAM.
        prefetch      = valid_q[LATENCY-1];
        capture       = valid_q[LATENCY];

        cap_entry.encrypt = dut_encrypt;
        cap_entry.decrypt = dut_decrypt;
        cap_entry.enc_ok  = (dut_encrypt == exp_head_q.cipher);
        cap_entry.dec_ok  = (dut_decrypt == exp_head_q.plain);
        cap_entry.tag     = exp_head_q.tag;

        inflight_d    = inflight_q + CW'(accept) - CW'(capture);
        res_cnt_d     = res_cnt_q + CW'(capture) - CW'(pop);
        res_rd_d      = pop ? ptr_inc(res_rd_q) : res_rd_q;
        head_from_cap = capture && ((res_cnt_q - CW'(pop)) == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (accept && in_eom) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_d == '0 && res_cnt_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
        // Registered from next-state counts, so it reflects the current credits exactly.
        in_ready_d = (state_d == ST_RUN) && ((inflight_d + res_cnt_d) < CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            inflight_q   <= '0;
            tag_q        <= '0;
            dut_plain_q  <= '0;
            dut_cipher_q <= '0;
            dut_key_q    <= '0;
            exp_wr_q     <= '0;
            exp_rd_q     <= '0;
            res_wr_q     <= '0;
            res_rd_q     <= '0;
            res_cnt_q    <= '0;
            res_valid_q  <= 1'b0;
            res_head_q   <= '0;
            pass_count_q <= '0;
            fail_count_q <= '0;
        end else begin
            valid_q    <= {valid_q[LATENCY-1:0], accept};
            inflight_q <= inflight_d;
            if (accept) begin
                dut_plain_q  <= in_plain;
                dut_cipher_q <= in_cipher;
                dut_key_q    <= in_key;
                tag_q        <= tag_q + 1'b1;
                exp_wr_q     <= ptr_inc(exp_wr_q);
            end
            if (prefetch) begin
                exp_rd_q <= ptr_inc(exp_rd_q);
            end
            if (capture) begin
                res_wr_q <= ptr_inc(res_wr_q);
                if (cap_entry.enc_ok && cap_entry.dec_ok) begin
                    if (pass_count_q != '1) pass_count_q <= pass_count_q + 1'b1;
                end else begin
                    if (fail_count_q != '1) fail_count_q <= fail_count_q + 1'b1;
                end
            end
            res_rd_q    <= res_rd_d;
            res_cnt_q   <= res_cnt_d;
            res_valid_q <= (res_cnt_d != '0);
            // A capture into an otherwise empty FIFO lands straight in the output register.
            if (head_from_cap) begin
                res_head_q <= cap_entry;
            end else if (res_cnt_d != '0) begin
                res_head_q <= res_mem[res_rd_d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            exp_mem[exp_wr_q] <= {in_cipher, in_plain, tag_q};
        end
        if (prefetch) begin
            exp_head_q <= exp_mem[exp_rd_q];
        end
        if (capture) begin
            res_mem[res_wr_q] <= cap_entry;
        end
    end

    assert property (@(posedge clock) disable iff (reset)
        !(capture && (res_cnt_q == CW'(DEPTH)) && !pop))
        else $error("result FIFO full at capture");

    assign in_ready    = in_ready_q;
    assign dut_plain   = dut_plain_q;
    assign dut_cipher  = dut_cipher_q;
    assign dut_key     = dut_key_q;
    assign res_valid   = res_valid_q;
    assign res_encrypt = res_head_q.encrypt;
    assign res_decrypt = res_head_q.decrypt;
    assign res_enc_ok  = res_head_q.enc_ok;
    assign res_dec_ok  = res_head_q.dec_ok;
    assign res_tag     = res_head_q.tag;
    assign pass_count  = pass_count_q;
    assign fail_count  = fail_count_q;
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_stream_transactor.sv
// Directed-plus-random bench for aes_stream_transactor with a toy fixed-latency core
// model (FIPS-197 known answer plus keyed XOR) and a queue-based reference scoreboard.
module tb_aes_stream_transactor;

    localparam int LAT = 10;
    localparam int DEP = 16;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset = 1'b1, in_valid = 1'b0, in_eom = 1'b0, res_ready = 1'b0;
    logic [127:0] in_plain = '0, in_cipher = '0, in_key = '0;
    logic [127:0] dut_encrypt, dut_decrypt;

    logic         in_ready, res_valid, res_enc_ok, res_dec_ok, done;
    logic [127:0] dut_plain, dut_cipher, dut_key, res_encrypt, res_decrypt;
    logic [15:0]  res_tag, pass_count, fail_count;

    logic         s_in_ready, s_res_valid, s_res_enc_ok, s_res_dec_ok, s_done;
    logic [127:0] s_dut_plain, s_dut_cipher, s_dut_key, s_res_encrypt, s_res_decrypt;
    logic [3:0]   s_res_tag, s_pass_count, s_fail_count;

    aes_stream_transactor #(.KEY_BITS(128), .LATENCY(LAT), .DEPTH(DEP), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_plain(in_plain), .in_cipher(in_cipher), .in_key(in_key), .in_eom(in_eom),
        .dut_plain(dut_plain), .dut_cipher(dut_cipher), .dut_key(dut_key),
        .dut_encrypt(dut_encrypt), .dut_decrypt(dut_decrypt),
        .res_valid(res_valid), .res_ready(res_ready), .res_encrypt(res_encrypt),
        .res_decrypt(res_decrypt), .res_enc_ok(res_enc_ok), .res_dec_ok(res_dec_ok),
        .res_tag(res_tag), .pass_count(pass_count), .fail_count(fail_count), .done(done)
    );

    // Narrow-counter instance shares all stimulus to exercise tag wrap and saturation.
    aes_stream_transactor #(.KEY_BITS(128), .LATENCY(LAT), .DEPTH(DEP), .CNT_W(4)) dut_s (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_plain(in_plain), .in_cipher(in_cipher), .in_key(in_key), .in_eom(in_eom),
        .dut_plain(s_dut_plain), .dut_cipher(s_dut_cipher), .dut_key(s_dut_key),
        .dut_encrypt(dut_encrypt), .dut_decrypt(dut_decrypt),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_encrypt(s_res_encrypt),
        .res_decrypt(s_res_decrypt), .res_enc_ok(s_res_enc_ok), .res_dec_ok(s_res_dec_ok),
        .res_tag(s_res_tag), .pass_count(s_pass_count), .fail_count(s_fail_count), .done(s_done)
    );

    function automatic logic [127:0] key_mask(input logic [127:0] k);
        return k ^ {k[63:0], k[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    function automatic logic [127:0] core_enc(input logic [127:0] p, input logic [127:0] k);
        return (p == FIPS_P && k == FIPS_K) ? FIPS_C : (p ^ key_mask(k));
    endfunction

    function automatic logic [127:0] core_dec(input logic [127:0] c, input logic [127:0] k);
        return (c == FIPS_C && k == FIPS_K) ? FIPS_P : (c ^ key_mask(k));
    endfunction

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Core model: results appear LAT cycles after dut_* is presented.
    logic [127:0] enc_pipe [LAT];
    logic [127:0] dec_pipe [LAT];
    always @(posedge clock) begin
        enc_pipe[0] <= core_enc(dut_plain, dut_key);
        dec_pipe[0] <= core_dec(dut_cipher, dut_key);
        for (int i = 1; i < LAT; i++) begin
            enc_pipe[i] <= enc_pipe[i-1];
            dec_pipe[i] <= dec_pipe[i-1];
        end
    end
    assign dut_encrypt = enc_pipe[LAT-1];
    assign dut_decrypt = dec_pipe[LAT-1];

    typedef struct {
        logic [127:0] p;
        logic [127:0] c;
        logic [127:0] k;
        int           n;
    } vec_t;

    vec_t         q[$];
    int           n_acc = 0, m_pass = 0, m_fail = 0;
    logic [127:0] last_p = '0, last_c = '0, last_k = '0;
    int           n_pass = 0, n_total = 0;
    int           cyc = 0, hs_cycle = 0, pop_cycle = 0, popped_n = -1;
    bit           hs_in_seen, hs_res_seen, done_at_neg, valid_at_neg;
    logic [1:0]   pop_ok;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic check_pop();
        vec_t v;
        logic [127:0] e, d;
        check("pop_has_expected", 128'(q.size() != 0), 128'd1);
        if (q.size() == 0) return;
        v = q.pop_front();
        popped_n = v.n;
        e = core_enc(v.p, v.k);
        d = core_dec(v.c, v.k);
        pop_ok = {res_enc_ok, res_dec_ok};
        $display("pop tag=%0d enc_ok=%0b dec_ok=%0b cyc=%0d", res_tag, res_enc_ok, res_dec_ok, cyc);
        check("res_tag", 128'(res_tag), 128'(v.n % 65536));
        check("res_encrypt", res_encrypt, e);
        check("res_decrypt", res_decrypt, d);
        check("res_oks", 128'({res_enc_ok, res_dec_ok}), 128'({e == v.c, d == v.p}));
        check("s_res_tag", 128'(s_res_tag), 128'(v.n % 16));
        check("s_res_oks", 128'({s_res_enc_ok, s_res_dec_ok}), 128'({e == v.c, d == v.p}));
        check("s_res_encrypt", s_res_encrypt, e);
        check("s_res_decrypt", s_res_decrypt, d);
    endtask

    task automatic tick();
        vec_t v;
        @(negedge clock);
        hs_in_seen   = 1'b0;
        hs_res_seen  = 1'b0;
        done_at_neg  = done;
        valid_at_neg = res_valid;
        if (reset) begin
            q.delete();
            n_acc  = 0;
            m_pass = 0;
            m_fail = 0;
        end else begin
            if (res_valid && res_ready) begin
                hs_res_seen = 1'b1;
                pop_cycle   = cyc;
                check_pop();
            end
            if (in_valid && in_ready) begin
                hs_in_seen = 1'b1;
                hs_cycle   = cyc;
                v.p = in_plain; v.c = in_cipher; v.k = in_key; v.n = n_acc;
                q.push_back(v);
                n_acc++;
                if (core_enc(in_plain, in_key) == in_cipher && core_dec(in_cipher, in_key) == in_plain)
                    m_pass++;
                else
                    m_fail++;
                last_p = in_plain; last_c = in_cipher; last_k = in_key;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic load_vec(input bit corrupt, input bit eom);
        logic [127:0] p, k;
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        in_plain  = p;
        in_key    = k;
        in_cipher = core_enc(p, k) ^ (corrupt ? 128'd1 : 128'd0);
        in_eom    = eom;
    endtask

    task automatic offer(input int count, input int budget, input bit eom_last,
                         input bit allow_fail, output int accepted);
        accepted = 0;
        load_vec(allow_fail && ($urandom_range(3) == 0), eom_last && count == 1);
        in_valid = 1'b1;
        for (int t = 0; t < budget && accepted < count; t++) begin
            tick();
            if (hs_in_seen) begin
                accepted++;
                if (accepted < count)
                    load_vec(allow_fail && ($urandom_range(3) == 0), eom_last && accepted == count - 1);
                else begin
                    in_valid = 1'b0;
                    in_eom   = 1'b0;
                end
            end
        end
    endtask

    task automatic send_one(input logic [127:0] p, input logic [127:0] c, input logic [127:0] k);
        bit got = 1'b0;
        in_plain = p; in_cipher = c; in_key = k; in_eom = 1'b0; in_valid = 1'b1;
        for (int t = 0; t < 20 && !got; t++) begin
            tick();
            got = hs_in_seen;
        end
        in_valid = 1'b0;
        check("send_accepted", 128'(got), 128'd1);
    endtask

    task automatic wait_pop(input int budget);
        bit got = 1'b0;
        for (int t = 0; t < budget && !got; t++) begin
            tick();
            got = hs_res_seen;
        end
        check("pop_seen", 128'(got), 128'd1);
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; in_eom = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_in_ready", 128'({in_ready, s_in_ready}), 128'd0);
        check("rst_res_valid", 128'({res_valid, s_res_valid}), 128'd0);
        check("rst_done", 128'({done, s_done}), 128'd0);
        check("rst_counts", 128'({pass_count, fail_count, s_pass_count, s_fail_count}), 128'd0);
        check("rst_res_fields", 128'({res_tag, res_enc_ok, res_dec_ok}), 128'd0);
        check("rst_res_data", res_encrypt | res_decrypt, 128'd0);
        check("rst_dut", dut_plain | dut_cipher | dut_key, 128'd0);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int t = 0; t < 400 && q.size() != 0; t++) tick();
        check("drain_empty", 128'(q.size()), 128'd0);
        tick();
        check("drain_idle", 128'(res_valid), 128'd0);
        check("pass_count", 128'(pass_count), 128'(sat(m_pass, 65535)));
        check("fail_count", 128'(fail_count), 128'(sat(m_fail, 65535)));
        check("s_pass_count", 128'(s_pass_count), 128'(sat(m_pass, 15)));
        check("s_fail_count", 128'(s_fail_count), 128'(sat(m_fail, 15)));
        check("dut_hold", {dut_plain ^ last_p} | {dut_cipher ^ last_c} | {dut_key ^ last_k}, 128'd0);
        check("s_dut_hold", {s_dut_plain ^ last_p} | {s_dut_cipher ^ last_c} | {s_dut_key ^ last_k}, 128'd0);
    endtask

    initial begin
        int  acc;
        int  stale;
        bit  got;

        // FIPS-197 known answer: latency, tag 0, both oks, pass_count.
        apply_reset();
        res_ready = 1'b1;
        send_one(FIPS_P, FIPS_C, FIPS_K);
        acc = hs_cycle;
        wait_pop(50);
        check("fips_latency", 128'(pop_cycle - acc), 128'(LAT + 2));
        check("fips_oks", 128'(pop_ok), 128'd3);
        check("fips_pass_count", 128'(pass_count), 128'd1);
        drain();

        // Corrupted expected ciphertext.
        apply_reset();
        res_ready = 1'b1;
        send_one(FIPS_P, FIPS_C ^ 128'd1, FIPS_K);
        wait_pop(50);
        check("corrupt_oks", 128'(pop_ok), 128'd0);
        check("corrupt_counts", 128'({pass_count, fail_count}), 128'({16'd0, 16'd1}));
        drain();

        // Backpressure: credits stop acceptance at DEPTH.
        apply_reset();
        res_ready = 1'b0;
        offer(20, 40, 1'b0, 1'b1, acc);
        check("bp_accepted", 128'(acc), 128'd16);
        check("bp_in_ready", 128'({in_ready, s_in_ready}), 128'd0);
        res_ready = 1'b1;
        offer(4, 100, 1'b0, 1'b1, acc);
        check("bp_rest_accepted", 128'(acc), 128'd4);
        drain();
        check("bp_total", 128'(n_acc), 128'd20);

        // End of message and drain to done.
        apply_reset();
        res_ready = 1'b1;
        offer(6, 100, 1'b1, 1'b1, acc);
        check("eom_accepted", 128'(acc), 128'd6);
        check("eom_in_ready", 128'(in_ready), 128'd0);
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            tick();
            got = hs_res_seen && (popped_n == 5);
        end
        check("eom_last_pop", 128'(got), 128'd1);
        check("done_at_pop", 128'(done_at_neg), 128'd0);
        check("done_after_pop", 128'(done), 128'd1);
        repeat (5) tick();
        check("done_sticky", 128'({done, s_done, in_ready}), 128'b110);
        drain();

        // Reset with 3 vectors in flight and 2 queued results.
        apply_reset();
        res_ready = 1'b0;
        offer(5, 30, 1'b0, 1'b1, acc);
        check("mid_accepted", 128'(acc), 128'd5);
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            tick();
            got = valid_at_neg;
        end
        check("mid_valid_seen", 128'(got), 128'd1);
        apply_reset();
        res_ready = 1'b1;
        stale = 0;
        repeat (2 * LAT) begin
            tick();
            if (valid_at_neg) stale++;
        end
        check("no_stale", 128'(stale), 128'd0);
        offer(1, 20, 1'b0, 1'b0, acc);
        wait_pop(50);
        check("post_reset_tag", 128'(popped_n), 128'd0);
        drain();

        // Counter saturation and tag wrap on the 4-bit instance.
        apply_reset();
        res_ready = 1'b1;
        offer(17, 200, 1'b0, 1'b0, acc);
        drain();
        check("sat_s_pass", 128'(s_pass_count), 128'd15);
        check("sat_pass", 128'(pass_count), 128'd17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_stream_transactor.md
# aes_stream_transactor

Synthesizable stream front end that feeds the AES encoder and decoder pair with test vectors, tracks in-flight vectors across the fixed-latency cores, and checks both results. It compares each result against the vector's own expected values and returns tagged pass/fail results over a ready/valid stream. It sits between the host-side input/output transport and the `AESEncoder`/`AESDecoder` instances. It replaces free-running, unchecked vector injection with credit-based flow control, in-order scoreboarding, end-of-message drain and pass/fail counters.

## Interface
- `KEY_BITS`, 128: key width (128/192/256); must match the cores.
- `LATENCY`, 10: cycles from a value on `dut_*` to the matching `dut_encrypt`/`dut_decrypt`; ≥1.
- `DEPTH`, 16: result FIFO depth and credit limit; must be ≥ `LATENCY`.
- `CNT_W`, 16: width of tag and counters.

Ports:
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1, `in_ready` out 1: vector handshake.
- `in_plain` in 128, `in_cipher` in 128, `in_key` in KEY_BITS: vector (plain, its ciphertext, key).
- `in_eom` in 1: marks the last vector; sampled on handshake.
- `dut_plain` out 128, `dut_cipher` out 128, `dut_key` out KEY_BITS: drive encoder/decoder inputs.
- `dut_encrypt` in 128, `dut_decrypt` in 128: encoder/decoder outputs.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_encrypt` out 128, `res_decrypt` out 128: raw core outputs.
- `res_enc_ok` out 1, `res_dec_ok` out 1: `res_encrypt==in_cipher`, `res_decrypt==in_plain` of the same vector.
- `res_tag` out CNT_W: acceptance sequence number, from 0, wraps modulo 2^CNT_W.
- `pass_count` out CNT_W, `fail_count` out CNT_W: saturating counters.
- `done` out 1: end of message fully drained.

## Operation
- **Reset values:** all outputs 0. This includes `dut_*`, `res_*`, the counters, `done` and `in_ready`. Reset also clears the FIFO, the valid pipe, the tag and the FSM, which goes to RUN.
- **FSM RUN:** `in_ready = (inflight + fifo_count) < DEPTH`.
  - On handshake, register the vector into `dut_*` and push {`in_cipher`, `in_plain`, tag} into the expected queue.
  - `dut_*` holds its last value when no vector is accepted.
  - A handshake with `in_eom=1` moves the FSM to DRAIN.
- **FSM DRAIN:** `in_ready=0`. Leave for DONE when `inflight==0` and the FIFO is empty.
- **FSM DONE:** `done=1`, `in_ready=0`. Exit only by reset.
- **In-flight tracking:** a `LATENCY`-deep shift register of valid bits. `inflight` is its popcount, or an equivalent up/down counter.
- **Capture:** when the valid bit emerges, capture `dut_encrypt`/`dut_decrypt`. Pop the expected queue, compare the full 128 bits of each, and push {outputs, oks, tag} into the result FIFO.
  - The result FIFO cannot overflow because of the credit limit.
  - If capture finds the FIFO full, that is a design error: flag it with an assertion.
- **Counters:** on capture, increment `pass_count` if both oks are 1, otherwise increment `fail_count`. Both saturate at 2^CNT_W−1.
- **Ordering:** results are strictly in acceptance order; tags are contiguous.
- **Reset mid-operation:** all in-flight and queued results are discarded. Core outputs still in the pipe after reset are ignored, because the valid bits are cleared.

## Timing
- Handshake at the end of cycle k → `dut_*` valid in cycle k+1.
- Core outputs are valid in cycle k+1+LATENCY and captured at the end of that cycle.
- `res_valid` rises in cycle k+2+LATENCY at the earliest; minimum latency is LATENCY+2.
- The result FIFO output is registered with no bypass. A push and a pop in the same cycle leaves the count unchanged.
- `in_ready` is registered-cone logic from state only and never depends on `in_valid`.
- A pop in cycle c frees a credit; `in_ready` may rise in cycle c+1.
- Throughput is 1 vector per cycle while `res_ready=1`.
- `done` rises the cycle after the last result is popped.
- After the eom handshake, `in_ready=0` from the next cycle.

## Test plan
1. **FIPS-197 vector:** plain 00112233445566778899aabbccddeeff, key 000102…0f, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, reference core model, `res_ready=1`. Expect `res_valid` at k+LATENCY+2 with both oks 1, `res_tag=0`, `pass_count=1`.
2. **Corrupted expected cipher:** same vector with `in_cipher` bit 0 flipped. Expect `res_enc_ok=0`, `res_dec_ok=0`, `fail_count=1`, `pass_count=0`.
3. **Backpressure:** DEPTH=16, `res_ready=0`, 20 valid vectors offered. Expect exactly 16 accepted and `in_ready` held 0. After releasing `res_ready`, expect all 20 results in order with tags 0..19 and no loss.
4. **End of message:** 6 vectors, the 6th with `in_eom`. Expect `in_ready=0` from the next cycle, `done=1` exactly one cycle after tag 5 pops, and `done` remaining 1.
5. **Reset mid-stream:** assert `reset` for 1 cycle with 3 vectors in flight and 2 queued. Expect all outputs 0 in the cycle after reset, no stale results afterwards, and the first new vector returned with tag 0.
6. **Counter saturation:** CNT_W=4, 17 passing vectors. Expect `pass_count=15` and `res_tag` sequence 0..15,0.
